rgb_led_sequencer: RTL and testbench
====================================

Name: rgb_led_sequencer

Overview:
- Register-programmed controller for the iCE40UP hard RGB LED driver.
- Generates the three PWM drive signals, the LED enable and the current-reference power-up (RGB_PU), in the required power sequence.
- Provides per-channel 8-bit duty and an optional per-channel "breathe" ramp.
- Sits between the SoC register bus (simple write strobe) and the RGB driver primitive.

Parameters:
- PU_DELAY, 16'd1200: clock cycles between RGB_PU rise and RGBLED_EN rise. The same delay applies from RGBLED_EN fall to RGB_PU fall. Legal range 1..65535.
- PRESCALE_RST, 8'd0: reset value of the prescaler register.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- wr_en  in  1  register write strobe, one cycle per write
- wr_addr  in  3  register address
- wr_data  in  8  register write data
- RGB0_PWM  out  1  channel 0 PWM to the driver
- RGB1_PWM  out  1  channel 1 PWM
- RGB2_PWM  out  1  channel 2 PWM
- RGBLED_EN  out  1  driver enable
- RGB_PU  out  1  driver current-reference power-up
- busy  out  1  high in any state other than IDLE or RUN
- state_o  out  2  current FSM state, for status readback

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (resetn). All flops reset asynchronously.
- Reset values: all outputs 0 (state_o = IDLE); CTRL, DUTY0..2 and all counters = 0; PRESCALE = PRESCALE_RST.
- Register map (write-only):
  - 0 CTRL: bit0 = run, bits[3:1] = breathe enable for channels 0..2.
  - 1 PRESCALE.
  - 2/3/4 DUTY0/1/2.
  - Addresses 5..7 are ignored.
  - Registers update on the cycle after wr_en.
- Prescaler: 8-bit counter pc.
  - When pc == PRESCALE, tick = 1 and pc returns to 0; otherwise pc increments.
  - PRESCALE = 0 gives a tick every cycle.
  - Counts only in RUN; held at 0 in all other states.
- PWM counter: 8-bit cnt, increments on tick, wraps 255 -> 0.
  - A frame boundary is a tick with cnt == 255.
- Shadowing: at each frame boundary, DUTYn is copied into shadow sdn. Mid-frame DUTY writes never change the current frame.
- Breathe: each channel has an 8-bit level lvln and a direction bit, both updated only at frame boundaries.
  - Breathe off: lvln = sdn.
  - Breathe on, up-ramp: lvln increments by 1 per frame until it reaches sdn, then the direction flips to down.
  - Down-ramp: lvln decrements until 0, then the direction flips to up.
  - If sdn drops below lvln while ramping, lvln is clamped to sdn and the direction is set to down.
  - Entering RUN sets lvln = 0, direction up.
- PWM output: RGBn_PWM is registered and equals (cnt < lvln) when in RUN; otherwise 0.
  - Duty 0 gives constant low; duty 255 gives high for 255 of 256 counts.
- FSM states:
  - IDLE (00): PU = 0, EN = 0. run = 1 -> PWRUP, wait counter loaded with PU_DELAY - 1.
  - PWRUP (01): PU = 1, EN = 0. Counter decrements. At counter == 0 -> RUN. If run = 0 at any time -> IDLE immediately (EN was never raised).
  - RUN (10): PU = 1, EN = 1, PWM active. run = 0 -> PWRDN; the PWM outputs are 0 from the next cycle; counter reloaded.
  - PWRDN (11): PU = 1, EN = 0, PWM = 0. Counter decrements. At 0 -> IDLE; if run = 1 at that point -> PWRUP instead. run toggles during PWRDN never shorten it.
- Entering RUN: pc = 0, cnt = 0, sdn = DUTYn (loaded immediately).
- Entering PWRUP: the wait counter is reloaded every time.
- Simultaneous wr_en to CTRL and a state transition: the FSM uses the registered run value, so the new value acts one cycle later.
- busy = (state == PWRUP) or (state == PWRDN).

Decomposition:
- Package rgb_seq_pkg holds:
  - state enum: IDLE = 2'b00, PWRUP = 2'b01, RUN = 2'b10, PWRDN = 2'b11;
  - register address constants: ADDR_CTRL = 0, ADDR_PRESCALE = 1, ADDR_DUTY0 = 2, ADDR_DUTY1 = 3, ADDR_DUTY2 = 4.
- One sub-module, rgb_pwm_channel, instantiated three times. It contains the shadow register, breathe level/direction logic and output compare. Inputs: cnt, frame boundary, run state, breathe enable, DUTYn.
- The top level holds the register file, prescaler, PWM counter and FSM.

Test Plan:
- Reset release, no writes -> all outputs 0 and state_o = 00 for 100 cycles.
- PU_DELAY = 4, write CTRL = 0x01 -> RGB_PU rises 2 cycles after wr_en (register then FSM). RGBLED_EN rises exactly 4 cycles after RGB_PU. busy is high in between.
- PRESCALE = 0, DUTY0 = 64, DUTY1 = 0, DUTY2 = 255, run -> per 256-cycle frame, RGB0_PWM is high for 64 cycles, RGB1_PWM constant 0, RGB2_PWM high for 255 cycles.
- Write DUTY0 = 128 at cnt = 10 -> current frame keeps 64 high counts; the next frame has 128.
- PRESCALE = 0, DUTY1 = 3, breathe bit1 set -> high counts per frame for channel 1 are 0, 1, 2, 3, 2, 1, 0, 1, ...
- In RUN, write CTRL = 0 -> all PWM outputs are 0 and RGBLED_EN = 0 the next cycle. RGB_PU falls PU_DELAY cycles later.
- PWRUP aborted by run = 0 -> immediate IDLE with RGBLED_EN never asserted.

Source files
------------

// File: rtl/rgb_seq_pkg.sv
// Shared definitions for the RGB LED sequencer: FSM state encoding and
// register map addresses.
package rgb_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    PWRUP = 2'b01,
    RUN   = 2'b10,
    PWRDN = 2'b11
  } seq_state_t;

  localparam logic [2:0] ADDR_CTRL     = 3'd0;
  localparam logic [2:0] ADDR_PRESCALE = 3'd1;
  localparam logic [2:0] ADDR_DUTY0    = 3'd2;
  localparam logic [2:0] ADDR_DUTY1    = 3'd3;
  localparam logic [2:0] ADDR_DUTY2    = 3'd4;

endpackage

// File: rtl/rgb_pwm_channel.sv
// One PWM channel: frame-shadowed duty, optional triangular breathe ramp,
// and the registered compare against the shared PWM counter.
module rgb_pwm_channel (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] cnt,
  input  logic       frame,
  input  logic       enter_run,
  input  logic       pwm_en,
  input  logic       breathe,
  input  logic [7:0] duty,
  output logic       pwm
);

  logic [7:0] sd;
  logic [7:0] lvl;
  logic       dir_up;
  logic [7:0] lvl_nx;
  logic       dir_nx;
  logic [7:0] level;
  logic       pwm_p1;

  // Ramp targets the shadow value that this boundary is about to load.
  always_comb begin
    lvl_nx = lvl;
    dir_nx = dir_up;
    if (!breathe) begin
      lvl_nx = duty;
      dir_nx = 1'b1;
    end else if (duty < lvl) begin
      lvl_nx = duty;
      dir_nx = 1'b0;
    end else if (dir_up) begin
      if (lvl < duty) begin
        lvl_nx = lvl + 8'd1;
      end else begin
        dir_nx = 1'b0;
        if (lvl != 8'd0) lvl_nx = lvl - 8'd1;
      end
    end else begin
      if (lvl != 8'd0) begin
        lvl_nx = lvl - 8'd1;
      end else begin
        dir_nx = 1'b1;
        if (lvl < duty) lvl_nx = lvl + 8'd1;
      end
    end
  end

  assign level = breathe ? lvl : sd;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sd     <= 8'd0;
      lvl    <= 8'd0;
      dir_up <= 1'b1;
      pwm_p1 <= 1'b0;
    end else begin
      if (enter_run) begin
        sd     <= duty;
        lvl    <= 8'd0;
        dir_up <= 1'b1;
      end else if (frame) begin
        sd     <= duty;
        lvl    <= lvl_nx;
        dir_up <= dir_nx;
      end
      pwm_p1 <= pwm_en && (cnt < level);
    end
  end

  assign pwm = pwm_p1;

endmodule

// File: rtl/rgb_led_sequencer.sv
// Register-programmed power sequencer and PWM generator for the iCE40UP
// hard RGB LED driver.
module rgb_led_sequencer
  import rgb_seq_pkg::*;
#(
  parameter logic [15:0] PU_DELAY     = 16'd1200,
  parameter logic [7:0]  PRESCALE_RST = 8'd0
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic       RGB0_PWM,
  output logic       RGB1_PWM,
  output logic       RGB2_PWM,
  output logic       RGBLED_EN,
  output logic       RGB_PU,
  output logic       busy,
  output logic [1:0] state_o
);

  logic [3:0]       ctrl;
  logic [7:0]       prescale;
  logic [2:0][7:0]  duty;
  seq_state_t       state, state_nx;
  logic [15:0]      wait_cnt, wait_nx;
  logic [7:0]       pc;
  logic [7:0]       cnt;
  logic             run;
  logic             in_run;
  logic             tick;
  logic             frame;
  logic             enter_run;
  logic             pwm_en;
  logic [2:0]       pwm;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ctrl     <= 4'd0;
      prescale <= PRESCALE_RST;
      duty     <= '0;
    end else if (wr_en) begin
      case (wr_addr)
        ADDR_CTRL:     ctrl     <= wr_data[3:0];
        ADDR_PRESCALE: prescale <= wr_data;
        ADDR_DUTY0:    duty[0]  <= wr_data;
        ADDR_DUTY1:    duty[1]  <= wr_data;
        ADDR_DUTY2:    duty[2]  <= wr_data;
        default:       ;
      endcase
    end
  end

  assign run = ctrl[0];

  always_comb begin
    state_nx = state;
    wait_nx  = wait_cnt;
    case (state)
      IDLE: begin
        if (run) begin
          state_nx = PWRUP;
          wait_nx  = PU_DELAY - 16'd1;
        end
      end
      PWRUP: begin
        if (!run)                  state_nx = IDLE;
        else if (wait_cnt == 16'd0) state_nx = RUN;
        else                       wait_nx  = wait_cnt - 16'd1;
      end
      RUN: begin
        if (!run) begin
          state_nx = PWRDN;
          wait_nx  = PU_DELAY - 16'd1;
        end
      end
      PWRDN: begin
        // The power-down wait always runs to completion before rearming.
        if (wait_cnt == 16'd0) begin
          if (run) begin
            state_nx = PWRUP;
            wait_nx  = PU_DELAY - 16'd1;
          end else begin
            state_nx = IDLE;
          end
        end else begin
          wait_nx = wait_cnt - 16'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      wait_cnt <= 16'd0;
    end else begin
      state    <= state_nx;
      wait_cnt <= wait_nx;
    end
  end

  assign in_run    = (state == RUN);
  assign tick      = in_run && (pc == prescale);
  assign frame     = tick && (cnt == 8'hFF);
  assign enter_run = (state != RUN) && (state_nx == RUN);
  // PWM drops together with the RUN exit, not a cycle after it.
  assign pwm_en    = in_run && (state_nx == RUN);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pc  <= 8'd0;
      cnt <= 8'd0;
    end else if (!in_run) begin
      pc  <= 8'd0;
      cnt <= 8'd0;
    end else begin
      pc <= tick ? 8'd0 : pc + 8'd1;
      if (tick) cnt <= cnt + 8'd1;
    end
  end

  for (genvar i = 0; i < 3; i++) begin : g_ch
    rgb_pwm_channel u_ch (
      .clk       (clk),
      .resetn    (resetn),
      .cnt       (cnt),
      .frame     (frame),
      .enter_run (enter_run),
      .pwm_en    (pwm_en),
      .breathe   (ctrl[i+1]),
      .duty      (duty[i]),
      .pwm       (pwm[i])
    );
  end

  assign RGB0_PWM  = pwm[0];
  assign RGB1_PWM  = pwm[1];
  assign RGB2_PWM  = pwm[2];
  assign RGB_PU    = (state != IDLE);
  assign RGBLED_EN = (state == RUN);
  assign busy      = (state == PWRUP) || (state == PWRDN);
  assign state_o   = state;

endmodule

// File: tb/tb_rgb_led_sequencer.sv
// Randomized self-checking bench for rgb_led_sequencer against a
// frame-level behavioural model of duty, shadowing, breathe and sequencing.
module tb_rgb_led_sequencer;

  localparam int PUD = 4;
  localparam logic [2:0] A_CTRL = 3'd0, A_PRE = 3'd1, A_D0 = 3'd2, A_D1 = 3'd3, A_D2 = 3'd4;

  logic       clk = 1'b0;
  logic       resetn;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  logic       RGB0_PWM, RGB1_PWM, RGB2_PWM, RGBLED_EN, RGB_PU, busy;
  logic [1:0] state_o;

  int n_checks = 0;
  int n_fail   = 0;

  rgb_led_sequencer #(.PU_DELAY(16'(PUD)), .PRESCALE_RST(8'd0)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .RGB0_PWM  (RGB0_PWM),
    .RGB1_PWM  (RGB1_PWM),
    .RGB2_PWM  (RGB2_PWM),
    .RGBLED_EN (RGBLED_EN),
    .RGB_PU    (RGB_PU),
    .busy      (busy),
    .state_o   (state_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic wait_rise0(output bit ok);
    logic prev;
    ok = 1'b0;
    prev = RGB0_PWM;
    for (int k = 0; k < 1000; k++) begin
      step();
      if (RGB0_PWM && !prev) begin
        ok = 1'b1;
        return;
      end
      prev = RGB0_PWM;
    end
  endtask

  // Starts the sequence and measures PU / EN latencies from the CTRL write.
  task automatic power_up(input logic [7:0] ctrl_val);
    int n, busy_lo;
    wr(A_CTRL, ctrl_val);
    n = 1;
    while (!RGB_PU && n < 50) begin step(); n++; end
    check("pu_rise_latency", n, 2);
    n = 0; busy_lo = 0;
    while (!RGBLED_EN && n < 50) begin
      if (!busy) busy_lo++;
      step(); n++;
    end
    check("en_after_pu", n, PUD);
    check("busy_in_pwrup", busy_lo, 0);
    check("state_run", int'(state_o), 2);
  endtask

  task automatic power_down();
    int n, busy_lo;
    wr(A_CTRL, 8'h00);
    n = 1;
    while (RGBLED_EN && n < 50) begin step(); n++; end
    check("en_fall_latency", n, 2);
    check("pwm_off_at_en_fall", int'({RGB2_PWM, RGB1_PWM, RGB0_PWM}), 0);
    n = 0; busy_lo = 0;
    while (RGB_PU && n < 50) begin
      if (!busy) busy_lo++;
      if (RGB0_PWM || RGB1_PWM || RGB2_PWM) busy_lo++;
      step(); n++;
    end
    check("pu_after_en", n, PUD);
    check("busy_in_pwrdn", busy_lo, 0);
    check("state_idle", int'(state_o), 0);
  endtask

  // Breathe level for frame k with peak d: triangle 0..d..0 of period 2d.
  function automatic int tri_level(input int k, input int d);
    int m;
    m = k % (2 * d);
    return (m <= d) ? m : 2 * d - m;
  endfunction

  initial begin
    int bad, p, len, c0, c1, c2, d1, d2, bd, en_seen;
    int dt[3];
    bit ok;

    resetn = 1'b0; wr_en = 1'b0; wr_addr = 3'd0; wr_data = 8'd0;
    repeat (3) step();
    resetn = 1'b1;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      if ({RGB0_PWM, RGB1_PWM, RGB2_PWM, RGBLED_EN, RGB_PU, busy, state_o} != 0) bad++;
      step();
    end
    check("reset_outputs_quiet", bad, 0);
    check("reset_state", int'(state_o), 0);

    // Plain duty: fixed corner case first, then randomized programs.
    for (int it = 0; it < 3; it++) begin
      if (it == 0) begin
        p = 0; dt[0] = 64; dt[1] = 0; dt[2] = 255;
      end else begin
        p = $urandom_range(3, 0);
        foreach (dt[j]) dt[j] = $urandom_range(255, 0);
      end
      wr(A_PRE, 8'(p));
      wr(A_D0, 8'(dt[0]));
      wr(A_D1, 8'(dt[1]));
      wr(A_D2, 8'(dt[2]));
      for (int a = 5; a < 8; a++) wr(3'(a), 8'($urandom_range(255, 0)));
      power_up(8'h01);
      len = 256 * (p + 1);
      c0 = 0; c1 = 0; c2 = 0;
      for (int i = 0; i < len; i++) begin
        step();
        c0 += int'(RGB0_PWM); c1 += int'(RGB1_PWM); c2 += int'(RGB2_PWM);
      end
      check("duty0_high", c0, dt[0] * (p + 1));
      check("duty1_high", c1, dt[1] * (p + 1));
      check("duty2_high", c2, dt[2] * (p + 1));
      power_down();
    end

    // Mid-frame duty write only takes effect on the following frame.
    wr(A_PRE, 8'd0);
    d1 = $urandom_range(200, 1);
    d2 = $urandom_range(255, 1);
    wr(A_D0, 8'(d1));
    power_up(8'h01);
    wait_rise0(ok);
    check("shadow_sync", int'(ok), 1);
    c0 = int'(RGB0_PWM);
    for (int i = 1; i < 256; i++) begin
      wr_en = (i == 10); wr_addr = A_D0; wr_data = 8'(d2);
      step();
      c0 += int'(RGB0_PWM);
    end
    wr_en = 1'b0;
    check("shadow_cur_frame", c0, d1);
    c0 = 0;
    for (int i = 0; i < 256; i++) begin
      c0 += int'(RGB0_PWM);
      step();
    end
    check("shadow_next_frame", c0, d2);
    power_down();

    // Breathe on channel 1, channel 0 used as frame reference.
    bd = $urandom_range(5, 1);
    wr(A_D0, 8'd16);
    wr(A_D1, 8'(bd));
    power_up(8'h05);
    wait_rise0(ok);
    check("breathe_sync", int'(ok), 1);
    for (int f = 0; f < 2 * bd + 3; f++) begin
      c1 = 0;
      for (int i = 0; i < 256; i++) begin
        c1 += int'(RGB1_PWM);
        step();
      end
      check($sformatf("breathe_f%0d", f), c1, tri_level(f, bd));
    end
    power_down();

    // Aborted power-up returns straight to IDLE without enabling the driver.
    en_seen = 0;
    wr(A_CTRL, 8'h01);
    step();
    check("abort_in_pwrup", int'(state_o), 1);
    wr(A_CTRL, 8'h00);
    en_seen += int'(RGBLED_EN);
    for (int i = 0; i < 2 * PUD; i++) begin
      step();
      en_seen += int'(RGBLED_EN);
    end
    check("abort_en_never", en_seen, 0);
    check("abort_state_idle", int'(state_o), 0);
    check("abort_pu_low", int'(RGB_PU), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
